// File: rtl/expr_pkg.sv
// Shared constants for the expression emitter and its recognizer bench:
// ASCII codes, one-hot FSM state encoding and the operator bit encoding.
package expr_pkg;

  localparam logic [7:0] ASC_ZERO = 8'd48;
  localparam logic [7:0] ASC_PLUS = 8'd43;
  localparam logic [7:0] ASC_STAR = 8'd42;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_DIG  = 3'b010,
    S_OP   = 3'b100
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/expr_emitter_if.sv
// Character stream handshake between the emitter (master) and a consumer
// (slave).
//   out_char  : ASCII byte, 0 when out_valid is low
//   out_valid : beat present
//   out_ready : consumer accepts the beat
//   out_last  : beat is the final operand of the expression
interface expr_emitter_if;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_char, output out_valid, output out_last, input out_ready);
  modport slave  (input out_char, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/expr_char_enc.sv
// Combinational ASCII encoder for the emitter.
//   state : current FSM state
//   nib   : current operand (BCD, already validated)
//   op    : current operator bit (0 = '+', 1 = '*')
//   ch    : ASCII byte; 0 outside DIG/OP so the idle bus stays quiet
module expr_char_enc
  import expr_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] nib,
  input  logic       op,
  output logic [7:0] ch
);

  always_comb begin
    ch = 8'd0;
    case (state)
      S_DIG:   ch = ASC_ZERO + {4'd0, nib};
      S_OP:    ch = (op == OP_MUL) ? ASC_STAR : ASC_PLUS;
      default: ch = 8'd0;
    endcase
  end

endmodule

// File: rtl/expr_emitter.sv
// Serializes a loaded expression (single-digit operands alternating with
// '+'/'*') into one ASCII character per accepted beat.
//   clk, clr : clock, synchronous active-high reset
//   start    : load request, sampled only in IDLE
//   digits   : BCD operands, operand i at [4i+3:4i], operand 0 first
//   ops      : operator i between operand i and i+1 (0 '+', 1 '*')
//   n_terms  : operand count
//   out_if   : character stream (master side)
//   busy     : not in IDLE
//   done     : one-cycle pulse after the final beat is accepted
//   err      : one-cycle pulse when a start is rejected
module expr_emitter
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8,
  parameter int CW        = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic [CW-1:0]          n_terms,
  expr_emitter_if.master         out_if,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t                 state_q, state_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          nt_q, nt_d;
  logic [4*MAX_TERMS-1:0] dig_q, dig_d;
  logic [MAX_TERMS-2:0]   ops_q, ops_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic       bad_load;
  logic [3:0] nib;
  logic       op_bit;
  logic       last;
  logic       hs;

  // Only operands that will actually be emitted must be valid BCD.
  always_comb begin
    bad_load = (n_terms == '0) || (n_terms > CW'(MAX_TERMS));
    for (int i = 0; i < MAX_TERMS; i++)
      if (CW'(i) < n_terms && digits[4*i +: 4] > 4'd9) bad_load = 1'b1;
  end

  // Operand/operator selected by idx; both decoded from registered state.
  always_comb begin
    nib    = 4'd0;
    op_bit = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++)
      if (idx_q == CW'(i)) nib = dig_q[4*i +: 4];
    for (int i = 0; i < MAX_TERMS-1; i++)
      if (idx_q == CW'(i)) op_bit = ops_q[i];
  end

  assign last = (state_q == S_DIG) && (idx_q == nt_q - CW'(1));
  assign hs   = out_if.out_valid && out_if.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nt_d    = nt_q;
    dig_d   = dig_q;
    ops_d   = ops_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (bad_load) err_d = 1'b1;
        else begin
          dig_d   = digits;
          ops_d   = ops;
          nt_d    = n_terms;
          idx_d   = '0;
          state_d = S_DIG;
        end
      end
      S_DIG: if (hs) begin
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else state_d = S_OP;
      end
      S_OP: if (hs) begin
        idx_d   = idx_q + CW'(1);
        state_d = S_DIG;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nt_q    <= '0;
      dig_q   <= '0;
      ops_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nt_q    <= nt_d;
      dig_q   <= dig_d;
      ops_q   <= ops_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  expr_char_enc u_enc (
    .state (state_q),
    .nib   (nib),
    .op    (op_bit),
    .ch    (out_if.out_char)
  );

  assign out_if.out_valid = (state_q == S_DIG) || (state_q == S_OP);
  assign out_if.out_last  = last;
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_expr_emitter.sv
module tb_expr_emitter;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic [3:0]  n_terms;
  logic        busy, done, err;

  always #5 clk = ~clk;

  expr_emitter_if sif ();

  expr_emitter #(.MAX_TERMS(8), .CW(4)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .digits  (digits),
    .ops     (ops),
    .n_terms (n_terms),
    .out_if  (sif.master),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Pops the scoreboard on every accepted beat; also checks that stalled
  // beats hold and that the bus reads 0 when idle.
  task automatic monitor();
    bit         pst = 1'b0;
    logic [7:0] pc  = 8'd0;
    logic       pl  = 1'b0;
    beat_t      e;
    forever begin
      @(negedge clk);
      if (pst) begin
        chk("hold_valid", int'(sif.out_valid), 1);
        chk("hold_char",  int'(sif.out_char), int'(pc));
        chk("hold_last",  int'(sif.out_last), int'(pl));
      end
      if (!sif.out_valid) chk("idle_char", int'(sif.out_char), 0);
      else if (sif.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got char %0d, none expected", sif.out_char);
        end else begin
          e = sb.pop_front();
          chk("beat_char", int'(sif.out_char), int'(e.ch));
          chk("beat_last", int'(sif.out_last), int'(e.last));
        end
      end
      pst = sif.out_valid && !sif.out_ready && !clr;
      pc  = sif.out_char;
      pl  = sif.out_last;
    end
  endtask

  task automatic run_expr(input string name, input logic [31:0] d, input logic [6:0] o,
                          input logic [3:0] n, input string exp, input bit stall,
                          input bit poke);
    int cyc;
    bit seen = 1'b0;
    for (int i = 0; i < exp.len(); i++)
      sb.push_back(beat_t'({exp[i], (i == exp.len() - 1)}));
    digits = d; ops = o; n_terms = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; digits = '1; ops = '1; n_terms = 4'd0;
    chk("busy_after_start", int'(busy), 1);
    for (cyc = 0; cyc < 200; cyc++) begin
      sif.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (poke && cyc == 1) begin
        start = 1'b1; digits = 32'h11111111; ops = '0; n_terms = 4'd2;
      end else start = 1'b0;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done, want done within 200 cycles", name);
    end else begin
      if (!stall) chk("done_latency", cyc, exp.len());
      chk("busy_at_done", int'(busy), 0);
      chk("sb_empty", sb.size(), 0);
    end
    @(posedge clk); #1;
    chk("done_single", int'(done), 0);
    chk("err_quiet", int'(err), 0);
  endtask

  task automatic rej(input string name, input logic [31:0] d, input logic [3:0] n);
    digits = d; ops = 7'b0; n_terms = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rej_err", int'(err), 1);
    chk("rej_busy", int'(busy), 0);
    chk("rej_valid", int'(sif.out_valid), 0);
    @(posedge clk); #1;
    chk("rej_err_pulse", int'(err), 0);
    chk("rej_busy2", int'(busy), 0);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; digits = '0; ops = '0; n_terms = '0;
    sif.out_ready = 1'b0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(sif.out_valid), 0);
    chk("rst_char",  int'(sif.out_char), 0);
    chk("rst_last",  int'(sif.out_last), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_err",   int'(err), 0);
    clr = 1'b0;
    @(posedge clk); #1;

    run_expr("three",    32'h00000943, 7'b0000010, 4'd3, "3+4*9", 1'b0, 1'b0);
    run_expr("single",   32'h00000007, 7'b0000000, 4'd1, "7", 1'b0, 1'b0);
    run_expr("stall",    32'h00000943, 7'b0000010, 4'd3, "3+4*9", 1'b1, 1'b0);
    run_expr("full",     32'h76543210, 7'b1010101, 4'd8, "0*1+2*3+4*5+6*7", 1'b0, 1'b0);
    run_expr("dontcare", 32'hFFFFFF95, 7'b1111110, 4'd2, "5+9", 1'b0, 1'b0);
    run_expr("poke",     32'h00000582, 7'b0000011, 4'd3, "2*8*5", 1'b1, 1'b1);

    rej("rej_n0",  32'h00000943, 4'd0);
    rej("rej_n9",  32'h00000943, 4'd9);
    rej("rej_hex", 32'h0000094A, 4'd3);
    rej("rej_mid", 32'h000000B3, 4'd2);

    // Abort during the second character.
    digits = 32'h00000943; ops = 7'b0000010; n_terms = 4'd3;
    sif.out_ready = 1'b1;
    sb.push_back(beat_t'({8'd51, 1'b0}));
    sb.push_back(beat_t'({8'd43, 1'b0}));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_valid", int'(sif.out_valid), 0);
    chk("clr_char",  int'(sif.out_char), 0);
    chk("clr_last",  int'(sif.out_last), 0);
    chk("clr_busy",  int'(busy), 0);
    chk("clr_done",  int'(done), 0);
    chk("clr_err",   int'(err), 0);
    @(posedge clk); #1;
    chk("clr_no_done", int'(done), 0);
    chk("clr_sb_empty", sb.size(), 0);

    run_expr("after_clr", 32'h00000009, 7'b0000001, 4'd2, "9*0", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expr_emitter.md
# expr_emitter

- Serializes a loaded arithmetic expression into an ASCII byte stream, one character per accepted beat.
- Expression form: single-digit operands alternating with `+` or `*`, e.g. "3+4*9".
- The stream is the transmit-side counterpart of the expression recognizer. It drives the recognizer's 8-bit character input in the string-checking datapath and in self-checking benches.
- Output uses a valid/ready handshake so a consumer can stall it.

## Interface

Parameters:
- `MAX_TERMS`, default 8: maximum number of operands; must be ≥2.
- `CW`, default 4: width of `n_terms`; must satisfy 2^CW > MAX_TERMS.

Ports:
- `clk`, in, 1: sole clock. All state changes on its rising edge.
- `clr`, in, 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `start`, in, 1: load request. Sampled only in IDLE.
- `digits`, in, 4*MAX_TERMS: BCD operands. Operand i is `digits[4i+3:4i]`; operand 0 is emitted first.
- `ops`, in, MAX_TERMS-1: operator i sits between operand i and operand i+1. 0 = `+` (43), 1 = `*` (42).
- `n_terms`, in, CW: number of operands to emit.
- `out_char`, out, 8: ASCII character.
- `out_valid`, out, 1: `out_char` is valid.
- `out_ready`, in, 1: consumer accepts the beat.
- `out_last`, out, 1: current beat is the final operand.
- `busy`, out, 1: high when not in IDLE.
- `done`, out, 1: one-cycle pulse after the last beat is accepted.
- `err`, out, 1: one-cycle pulse when a `start` is rejected.

## Operation

- FSM, one-hot: IDLE=3'b001, DIG=3'b010, OP=3'b100. Any other encoding returns to IDLE on the next edge.
- **IDLE**, on `start`:
  - Reject if `n_terms`==0, or `n_terms`>MAX_TERMS, or any operand with index < `n_terms` is >9.
  - On reject: pulse `err`, stay in IDLE, register nothing.
  - Otherwise latch `digits`, `ops` and `n_terms`, set idx=0, go to DIG.
  - Operands and operators at positions ≥ `n_terms` are don't-care.
- **DIG**:
  - `out_valid`=1, `out_char` = 48 + operand[idx].
  - `out_last` = (idx == n_terms-1).
  - On handshake (`out_valid`&&`out_ready`): if `out_last`, go to IDLE and pulse `done` in the following cycle; otherwise go to OP.
- **OP**:
  - `out_valid`=1, `out_char` = ops[idx] ? 42 : 43, `out_last`=0.
  - On handshake: idx←idx+1, go to DIG.
- Stall: while `out_ready`=0, state, idx, `out_char` and `out_last` hold stable. `out_valid` never drops before a handshake.
- `start` while busy is ignored: no `err`, latched data untouched.
- Stream length: exactly 2·`n_terms`−1 characters, always starting and ending with a digit, so the recognizer's output is high on every digit beat.
- `out_char` is 0 whenever `out_valid`=0.

## Timing

- Reset: `clr`=1 at an edge forces IDLE, idx=0 and clears latched data. After that edge `out_valid`, `out_last`, `busy`, `done`, `err` are 0 and `out_char`=8'd0.
- `clr` mid-stream aborts immediately; no `done`. `clr` has priority over `start` and over a handshake in the same cycle.
- `start` accepted at edge t: `busy` and `out_valid` are high from t onward (first character visible in cycle t+1), i.e. one cycle of latency.
- With `out_ready` held high: one character per cycle. The last beat is accepted at edge t+2n−1, `done` is high in the following cycle, `busy` is low in that same cycle.
- A new `start` is accepted in the cycle `done` is high, giving back-to-back expressions with a one-cycle gap.
- `err` and `done` are registered single-cycle pulses.
- `out_*` are decoded from registered state and latched data; no combinational path from `out_ready` to `out_char`.

## Structure

- Shared package `expr_pkg` holds:
  - ASCII constants: ASC_ZERO=48, ASC_PLUS=43, ASC_STAR=42.
  - One-hot state constants: S_IDLE, S_DIG, S_OP.
  - Operator encoding: OP_ADD=0, OP_MUL=1.
- One natural sub-module, `expr_char_enc`: combinational; takes state, operand nibble and op bit, produces the ASCII byte. The recognizer's bench reuses its constants.
- The remainder is a single FSM plus an idx counter of width CW.

## Test plan

- **Three terms, no stall.** `n_terms`=3, operands 3,4,9, `ops`=2'b10, `out_ready`=1 → chars 51,43,52,42,57 on 5 consecutive cycles; `out_last` only on 57; `done` the next cycle.
- **Single term.** `n_terms`=1, operand 7 → one beat of 55 with `out_last`=1; `done` follows.
- **Backpressure.** `out_ready` toggled 1,0,0,1,… → every character held stable through the stall; no beat lost or duplicated; sequence identical to the no-stall case.
- **Rejects.** `n_terms`=0, or `n_terms`=9 with MAX_TERMS=8, or operand 0 = 4'hA → `err` pulses once, `busy` stays 0, no `out_valid`.
- **Reset and start-while-busy.** `clr` asserted during the 2nd character → next cycle all outputs 0, no `done`. A `start` during streaming → ignored, stream unchanged.
- **Loopback.** Feed accepted beats to the recognizer for random valid expressions → recognizer never enters its error state, and its output is high on every digit beat.
